exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameters: none; datapath fixed at 32 bits.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low; clock clk.
REQ-004 instr  input  32  current RV32I instruction word.
REQ-005 rs1_data  input  32  source register 1 value.
REQ-006 rs2_data  input  32  source register 2 value.
REQ-007 alu_en  input  1  ALU result capture enable.
REQ-008 br_en  input  1  branch comparison capture enable.
REQ-009 imm  output  32  decoded immediate, combinational.
REQ-010 alu_res  output  32  registered ALU result.
REQ-011 br_taken  output  1  registered branch decision.

Function
REQ-012 Fields: opcode=instr[6:0], funct3=instr[14:12], funct7=instr[31:25].
REQ-013 imm SHALL be purely combinational from instr, sign-extended from instr[31], per opcode:
- I-type (0000011, 0010011, 1100111, 1110011): instr[31:20].
- S-type (0100011): {instr[31:25], instr[11:7]}.
- B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U-type (0110111, 0010111): {instr[31:12], 12'b0}, no extension needed.
- J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Any other opcode: 0.
REQ-014 ALU operand A = rs1_data; operand B = rs2_data when opcode[5]=1, else imm.
REQ-015 ALU ops by funct3:
- 000: ADD; SUB only when opcode[5]=1 and funct7[5]=1.
- 001: SLL.
- 010: SLT, signed, result 0/1.
- 011: SLTU, unsigned, result 0/1.
- 100: XOR.
- 101: SRL when funct7[5]=0, SRA when funct7[5]=1, for both register and immediate forms.
- 110: OR.
- 111: AND.
REQ-016 Shift amount = B[4:0]; upper bits ignored.
REQ-017 All arithmetic is modulo 2^32; overflow is ignored.
REQ-018 Branch compare of rs1_data vs rs2_data by funct3:
- 000 BEQ, 001 BNE.
- 100 BLT, 101 BGE (signed).
- 110 BLTU, 111 BGEU (unsigned).
- 010, 011: not taken.
REQ-019 At each rising edge with rst_n=1:
- alu_res <= ALU result if alu_en=1, else 0.
- br_taken <= branch result if br_en=1, else 0.
REQ-020 Latency: one cycle. Outputs reflect the inputs present at the previous edge; inputs must be held stable across that edge.
REQ-021 alu_en and br_en are independent; both high at once updates both outputs from the same inputs.
REQ-022 ALU and branch results are computed for every instr regardless of opcode; the enables alone govern capture.
REQ-023 imm never depends on clk, rst_n or the enables.

Reset
REQ-024 rst_n=0 at a rising edge SHALL set alu_res=0 and br_taken=0, overriding alu_en and br_en.
REQ-025 imm stays combinational during reset.
REQ-026 Reset asserted mid-operation discards any pending result.
REQ-027 The first capture occurs at the first edge with rst_n=1.

Verification
REQ-028 ADD/SUB, rs1=5, rs2=7, alu_en=1:
- instr 0x002081B3 -> alu_res=0x0000000C next cycle.
- instr 0x402081B3 -> 0xFFFFFFFE.
REQ-029 Immediate forms, alu_en=1:
- ADDI instr 0xFFF08193, rs1=0 -> imm=0xFFFFFFFF, alu_res=0xFFFFFFFF.
- SRAI instr 0x4040D193, rs1=0x80000000 -> alu_res=0xF8000000.
REQ-030 imm decode:
- 0xFE20AC23 (SW) -> 0xFFFFFFF8.
- 0xFFDFF0EF (JAL) -> 0xFFFFFFFC.
- 0x12345037 (LUI) -> 0x12345000.
- 0x00100073 (EBREAK) -> 0x00000001.
REQ-031 Branches, rs1=0xFFFFFFFF, rs2=1, br_en=1:
- instr 0x0020C063 (BLT) -> br_taken=1.
- instr 0x0020E063 (BLTU) -> br_taken=0.
- rs1=rs2 with BEQ 0x00208063 -> br_taken=1.
REQ-032 Enable low: deassert alu_en/br_en after a capture -> alu_res=0 and br_taken=0 at the next edge.
REQ-033 Reset priority: rst_n=0 with alu_en=1 and a nonzero ADD -> alu_res=0 and br_taken=0 after the edge.

Source files
------------

// File: rtl/exec_unit.sv
// RV32I execute stage: combinational immediate decode, ALU and branch compare,
// with ALU result and branch decision registered behind independent capture enables.
module exec_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        alu_en,
    input  logic        br_en,
    output logic [31:0] imm,
    output logic [31:0] alu_res,
    output logic        br_taken
);

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_SYSTEM = 7'b1110011
    } opcode_e;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } alu_f3_e;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } br_f3_e;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic        reg_form;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [31:0] alu_next;
    logic        br_next;
    logic        eq;
    logic        lt_s;
    logic        lt_u;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7_b5 = instr[30];
    assign reg_form  = opcode[5];

    // Immediate decode depends only on instr, never on clock, reset or enables.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        imm = 32'd0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
                imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {instr[31:12], 12'd0};
            OP_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = 32'd0;
        endcase
    end

    assign op_a  = rs1_data;
    assign op_b  = reg_form ? rs2_data : imm;
    assign shamt = op_b[4:0];

    // Immediate shifts carry the SRA select in imm bit 10, which is instr[30] as well.
    always_comb begin
        alu_next = 32'd0;
        case (funct3)
            F3_ADD:  alu_next = (reg_form && funct7_b5) ? op_a - op_b : op_a + op_b;
            F3_SLL:  alu_next = op_a << shamt;
            F3_SLT:  alu_next = {31'd0, $signed(op_a) < $signed(op_b)};
            F3_SLTU: alu_next = {31'd0, op_a < op_b};
            F3_XOR:  alu_next = op_a ^ op_b;
            F3_SR:   alu_next = funct7_b5 ? 32'($signed(op_a) >>> shamt) : op_a >> shamt;
            F3_OR:   alu_next = op_a | op_b;
            F3_AND:  alu_next = op_a & op_b;
            default: alu_next = 32'd0;
        endcase
    end

    assign eq   = (rs1_data == rs2_data);
    assign lt_s = ($signed(rs1_data) < $signed(rs2_data));
    assign lt_u = (rs1_data < rs2_data);

    always_comb begin
        br_next = 1'b0;
        case (funct3)
            F3_BEQ:  br_next = eq;
            F3_BNE:  br_next = !eq;
            F3_BLT:  br_next = lt_s;
            F3_BGE:  br_next = !lt_s;
            F3_BLTU: br_next = lt_u;
            F3_BGEU: br_next = !lt_u;
            default: br_next = 1'b0;
        endcase
    end

    // Outputs drop to zero on any cycle whose enable is low; reset overrides both enables.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            alu_res  <= 32'd0;
            br_taken <= 1'b0;
        end else begin
            alu_res  <= alu_en ? alu_next : 32'd0;
            br_taken <= br_en & br_next;
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit: expected results go to a scoreboard
// queue when stimulus is applied and are popped when the registered outputs appear.
module tb_exec_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        alu_en;
    logic        br_en;
    logic [31:0] imm;
    logic [31:0] alu_res;
    logic        br_taken;

    typedef struct {
        string       tag;
        logic [31:0] alu;
        logic        br;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    exec_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .instr    (instr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .alu_en   (alu_en),
        .br_en    (br_en),
        .imm      (imm),
        .alu_res  (alu_res),
        .br_taken (br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Apply one set of inputs at the falling edge, capture at the rising edge, compare 1 ns later.
    task automatic step(input string tag, input logic rst, input logic [31:0] ins,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic ae, input logic be,
                        input logic [31:0] exp_alu, input logic exp_br);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst_n    = rst;
        instr    = ins;
        rs1_data = a;
        rs2_data = b;
        alu_en   = ae;
        br_en    = be;
        e.tag = tag;
        e.alu = exp_alu;
        e.br  = exp_br;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        assert (sb.size() > 0)
        else begin
            errors++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check({got.tag, "_alu"}, alu_res, got.alu);
            check({got.tag, "_br"}, {31'd0, br_taken}, {31'd0, got.br});
        end
    endtask

    task automatic check_imm(input string tag, input logic [31:0] ins, input logic [31:0] exp_imm);
        @(negedge clk);
        instr  = ins;
        alu_en = 1'b0;
        br_en  = 1'b0;
        #1;
        check(tag, imm, exp_imm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        instr    = 32'd0;
        rs1_data = 32'd0;
        rs2_data = 32'd0;
        alu_en   = 1'b0;
        br_en    = 1'b0;

        // Reset overrides enables; imm stays live during reset.
        step("reset_add", 1'b0, 32'h002081B3, 32'd5, 32'd7, 1'b1, 1'b1, 32'd0, 1'b0);
        @(negedge clk);
        instr = 32'hFFF08193;
        #1;
        check("imm_in_reset", imm, 32'hFFFFFFFF);

        // First capture right after reset release.
        step("add",  1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b1, 1'b0, 32'h0000000C, 1'b0);
        step("sub",  1'b1, 32'h402081B3, 32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0);
        step("add_wrap", 1'b1, 32'h002081B3, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0, 32'h00000000, 1'b0);

        // Immediate forms.
        step("addi", 1'b1, 32'hFFF08193, 32'd0, 32'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0);
        step("srai", 1'b1, 32'h4040D193, 32'h80000000, 32'd0, 1'b1, 1'b0, 32'hF8000000, 1'b0);

        // Register ALU ops, a=0xFFFFFFF0, b=0x23 (shift amount 3).
        step("sll",  1'b1, 32'h002091B3, 32'hFFFFFFF0, 32'h23, 1'b1, 1'b0, 32'hFFFFFF80, 1'b0);
        step("slt",  1'b1, 32'h0020A1B3, 32'hFFFFFFF0, 32'h23, 1'b1, 1'b0, 32'h00000001, 1'b0);
        step("sltu", 1'b1, 32'h0020B1B3, 32'hFFFFFFF0, 32'h23, 1'b1, 1'b0, 32'h00000000, 1'b0);
        step("xor",  1'b1, 32'h0020C1B3, 32'hFFFFFFF0, 32'h23, 1'b1, 1'b0, 32'hFFFFFFD3, 1'b0);
        step("srl",  1'b1, 32'h0020D1B3, 32'hFFFFFFF0, 32'h23, 1'b1, 1'b0, 32'h1FFFFFFE, 1'b0);
        step("sra",  1'b1, 32'h4020D1B3, 32'hFFFFFFF0, 32'h23, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0);
        step("or",   1'b1, 32'h0020E1B3, 32'hFFFFFFF0, 32'h23, 1'b1, 1'b0, 32'hFFFFFFF3, 1'b0);
        step("and",  1'b1, 32'h0020F1B3, 32'hFFFFFFF0, 32'h23, 1'b1, 1'b0, 32'h00000020, 1'b0);

        // Immediate decode per format, including an unknown opcode.
        check_imm("imm_sw",     32'hFE20AC23, 32'hFFFFFFF8);
        check_imm("imm_jal",    32'hFFDFF0EF, 32'hFFFFFFFC);
        check_imm("imm_lui",    32'h12345037, 32'h12345000);
        check_imm("imm_ebreak", 32'h00100073, 32'h00000001);
        check_imm("imm_branch", 32'hFE000EE3, 32'hFFFFFFFC);
        check_imm("imm_unknown", 32'hFFFFFFFF, 32'h00000000);

        // Branches with rs1=-1, rs2=1; alu_en low so alu_res must read zero.
        step("blt",  1'b1, 32'h0020C063, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1, 32'd0, 1'b1);
        step("bltu", 1'b1, 32'h0020E063, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1, 32'd0, 1'b0);
        step("bne",  1'b1, 32'h00209063, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1, 32'd0, 1'b1);
        step("bge",  1'b1, 32'h0020D063, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1, 32'd0, 1'b0);
        step("bgeu", 1'b1, 32'h0020F063, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1, 32'd0, 1'b1);
        step("br_f3_010", 1'b1, 32'h0020A063, 32'd3, 32'd3, 1'b0, 1'b1, 32'd0, 1'b0);
        step("beq",  1'b1, 32'h00208063, 32'd9, 32'd9, 1'b0, 1'b1, 32'd0, 1'b1);

        // Both enables on one R-type ADD: ALU sum and funct3=000 compare (BEQ) together.
        step("both_en", 1'b1, 32'h002081B3, 32'd3, 32'd3, 1'b1, 1'b1, 32'd6, 1'b1);
        // Enables dropped after a capture clear both outputs.
        step("en_low", 1'b1, 32'h002081B3, 32'd3, 32'd3, 1'b0, 1'b0, 32'd0, 1'b0);

        // Reset in the middle of operation discards the pending result, then capture resumes.
        step("pre_rst", 1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b1, 1'b1, 32'h0000000C, 1'b0);
        step("mid_rst", 1'b0, 32'h002081B3, 32'd5, 32'd7, 1'b1, 1'b1, 32'd0, 1'b0);
        step("post_rst", 1'b1, 32'h402081B3, 32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0);

        checks++;
        assert (sb.size() == 0)
        else begin
            errors++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
